blinky_led_pio_ctrl: RTL and testbench



---
 rtl/blinky_led_pio_ctrl.sv | 104 ++++++++++
 tb/tb_blinky_led_pio_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/blinky_led_pio_ctrl.sv
// Avalon-MM LED output port with atomic set/clear/toggle registers and a
// per-bit hardware blink engine driven by a programmable half-period divider.
module blinky_led_pio_ctrl #(
    parameter int unsigned WIDTH        = 17,
    parameter logic [31:0] RESET_VALUE  = 32'h0,
    parameter int unsigned DIV_WIDTH    = 24,
    parameter logic [31:0] PERIOD_RESET = 32'd12499999
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    localparam logic [2:0] AddrData   = 3'd0;
    localparam logic [2:0] AddrMode   = 3'd1;
    localparam logic [2:0] AddrPeriod = 3'd2;
    localparam logic [2:0] AddrStatus = 3'd3;
    localparam logic [2:0] AddrSet    = 3'd4;
    localparam logic [2:0] AddrClear  = 3'd5;
    localparam logic [2:0] AddrToggle = 3'd6;

    logic [WIDTH-1:0]     data_q, data_d;
    logic [WIDTH-1:0]     mode_q, mode_d;
    logic [DIV_WIDTH-1:0] period_q, period_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic                 phase_q, phase_d;

    logic                 wr_en;
    logic [WIDTH-1:0]     wdata_mask;
    logic [DIV_WIDTH-1:0] wdata_period;
    logic                 unused_writedata;

    assign wr_en        = chipselect & ~write_n;
    assign wdata_mask   = writedata[WIDTH-1:0];
    assign wdata_period = writedata[DIV_WIDTH-1:0];
    // Upper writedata bits are deliberately dropped for narrow configurations.
    assign unused_writedata = ^writedata;

    always_comb begin
        data_d   = data_q;
        mode_d   = mode_q;
        period_d = period_q;
        cnt_d    = cnt_q + DIV_WIDTH'(1);
        phase_d  = phase_q;

        if (cnt_q == period_q) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end

        // A PERIOD write restarts the divider and overrides any wrap this cycle.
        if (wr_en) begin
            case (address)
                AddrData:   data_d = wdata_mask;
                AddrMode:   mode_d = wdata_mask;
                AddrPeriod: begin
                    period_d = wdata_period;
                    cnt_d    = '0;
                    phase_d  = 1'b1;
                end
                AddrSet:    data_d = data_q | wdata_mask;
                AddrClear:  data_d = data_q & ~wdata_mask;
                AddrToggle: data_d = data_q ^ wdata_mask;
                default:    ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q   <= RESET_VALUE[WIDTH-1:0];
            mode_q   <= '0;
            period_q <= PERIOD_RESET[DIV_WIDTH-1:0];
            cnt_q    <= '0;
            phase_q  <= 1'b1;
        end else begin
            data_q   <= data_d;
            mode_q   <= mode_d;
            period_q <= period_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            AddrData:   readdata = 32'(data_q);
            AddrMode:   readdata = 32'(mode_q);
            AddrPeriod: readdata = 32'(period_q);
            AddrStatus: readdata = {31'b0, phase_q};
            default:    readdata = '0;
        endcase
    end

    // Blink bits are gated low during the off phase; only registers feed the pins.
    assign out_port = data_q & ~(mode_q & {WIDTH{~phase_q}});

endmodule

// File: tb/tb_blinky_led_pio_ctrl.sv
// Directed and randomized checks of blinky_led_pio_ctrl against a cycle-count
// based reference model of the register file and blink phase.
module tb_blinky_led_pio_ctrl;

    localparam int unsigned W  = 17;
    localparam int unsigned DW = 24;
    localparam logic [31:0] RV = 32'h00005;
    localparam logic [31:0] PR = 32'd12499999;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [2:0]    address = '0;
    logic          chipselect = 1'b0;
    logic          write_n = 1'b1;
    logic [31:0]   writedata = '0;
    logic [31:0]   readdata;
    logic [W-1:0]  out_port;

    int checks = 0;
    int errors = 0;

    // Reference model: registers plus edges elapsed since the last divider restart.
    logic [W-1:0]  m_data;
    logic [W-1:0]  m_mode;
    logic [DW-1:0] m_period;
    longint        k;

    blinky_led_pio_ctrl #(
        .WIDTH       (W),
        .RESET_VALUE (RV),
        .DIV_WIDTH   (DW),
        .PERIOD_RESET(PR)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .out_port  (out_port)
    );

    always #5 clk = ~clk;

    function automatic logic m_phase();
        longint q;
        q = k / (longint'(m_period) + 1);
        return ~q[0];
    endfunction

    function automatic logic [W-1:0] m_out();
        return m_data & ~(m_mode & {W{~m_phase()}});
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] a);
        case (a)
            3'd0:    return 32'(m_data);
            3'd1:    return 32'(m_mode);
            3'd2:    return 32'(m_period);
            3'd3:    return {31'b0, m_phase()};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_data   = RV[W-1:0];
        m_mode   = '0;
        m_period = PR[DW-1:0];
        k        = 0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic read_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
        address = a;
        #1;
        check(tag, readdata, exp);
    endtask

    // Check the pins and one randomly chosen register against the model.
    task automatic check_state(input string tag);
        logic [2:0] a;
        check({tag, "/out_port"}, 32'(out_port), 32'(m_out()));
        a = 3'($urandom_range(0, 7));
        read_chk({tag, "/readdata"}, a, m_read(a));
    endtask

    // One bus cycle; the model advances on the same edge as the DUT.
    task automatic bus(input logic cs, input logic wn, input logic [2:0] a,
                       input logic [31:0] d, input string tag);
        bit restart;
        restart    = 1'b0;
        chipselect = cs;
        write_n    = wn;
        address    = a;
        writedata  = d;
        @(posedge clk);
        if (cs && !wn) begin
            case (a)
                3'd0: m_data = d[W-1:0];
                3'd1: m_mode = d[W-1:0];
                3'd2: begin
                    m_period = d[DW-1:0];
                    k        = 0;
                    restart  = 1'b1;
                end
                3'd4: m_data = m_data | d[W-1:0];
                3'd5: m_data = m_data & ~d[W-1:0];
                3'd6: m_data = m_data ^ d[W-1:0];
                default: ;
            endcase
        end
        if (!restart) k++;
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        check_state(tag);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d, input string tag);
        bus(1'b1, 1'b0, a, d, tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) bus(1'b0, 1'b1, 3'd0, 32'h0, tag);
    endtask

    // Asynchronous reset pulse asserted mid-cycle, held for two edges.
    task automatic reset_pulse(input string tag);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        model_reset();
        check({tag, "/async_out"}, 32'(out_port), RV);
        repeat (2) @(posedge clk);
        #1;
        check({tag, "/held_out"}, 32'(out_port), RV);
        read_chk({tag, "/data"}, 3'd0, RV);
        read_chk({tag, "/mode"}, 3'd1, 32'h0);
        read_chk({tag, "/period"}, 3'd2, PR);
        read_chk({tag, "/status"}, 3'd3, 32'h1);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("por/out_port", 32'(out_port), RV);
        read_chk("por/data", 3'd0, RV);
        read_chk("por/period", 3'd2, PR);
        @(negedge clk);
        reset_n = 1'b1;

        // Dirty the state, then reset asynchronously mid-cycle.
        wr(3'd0, 32'h0001_2340, "pre_reset_data");
        wr(3'd1, 32'h0000_00ff, "pre_reset_mode");
        reset_pulse("reset");

        // Atomic bit operations.
        wr(3'd0, 32'hffff_ffff, "data_all");
        read_chk("data_all_rd", 3'd0, 32'h0001_ffff);
        wr(3'd5, 32'h0000_f0f0, "outclear");
        read_chk("outclear_rd", 3'd0, 32'h0001_0f0f);
        wr(3'd4, 32'h0000_00f0, "outset");
        read_chk("outset_rd", 3'd0, 32'h0001_0fff);
        wr(3'd6, 32'h0001_0001, "outtoggle");
        read_chk("outtoggle_rd", 3'd0, 32'h0000_0ffe);
        for (int a = 4; a < 8; a++) read_chk("wo_reads_zero", 3'(a), 32'h0);

        // Blink with half-period of 4 cycles on bit0, static bit1.
        wr(3'd2, 32'd3, "blink_period");
        wr(3'd0, 32'h3, "blink_data");
        wr(3'd1, 32'h1, "blink_mode");
        for (int i = 0; i < 16; i++) begin
            bus(1'b0, 1'b1, 3'd0, 32'h0, "blink_run");
            check("blink_bit1", 32'(out_port[1]), 32'h1);
            read_chk("blink_status", 3'd3, 32'(out_port[0]));
        end

        // PERIOD restart while in the low phase at cnt=5.
        wr(3'd2, 32'd9, "restart_p9");
        idle(15, "restart_wait");
        read_chk("restart_pre_phase", 3'd3, 32'h0);
        wr(3'd2, 32'd2, "restart_p2");
        read_chk("restart_phase1", 3'd3, 32'h1);
        idle(2, "restart_hold");
        read_chk("restart_still1", 3'd3, 32'h1);
        idle(1, "restart_toggle");
        read_chk("restart_toggled", 3'd3, 32'h0);

        // Minimum period toggles every cycle.
        wr(3'd2, 32'd0, "period0");
        idle(4, "period0_run");

        // Ignored writes.
        bus(1'b0, 1'b0, 3'd0, 32'h0000_1234, "no_cs_write");
        read_chk("no_cs_data", 3'd0, 32'h0000_0003);
        wr(3'd7, 32'hffff_ffff, "reserved_write");
        read_chk("reserved_data", 3'd0, 32'h0000_0003);
        read_chk("reserved_mode", 3'd1, 32'h0000_0001);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            logic [2:0]  a;
            logic [31:0] d;
            a = 3'($urandom_range(0, 7));
            d = (a == 3'd2) ? 32'($urandom_range(0, 5)) | ($urandom & 32'hff00_0000)
                            : $urandom;
            bus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), a, d, "random");
        end

        // Reset during fast blinking.
        wr(3'd2, 32'd1, "midblink_period");
        wr(3'd0, 32'h1ffff, "midblink_data");
        wr(3'd1, 32'h1ffff, "midblink_mode");
        idle(5, "midblink_run");
        reset_pulse("midblink_reset");
        for (int i = 0; i < 6; i++) begin
            idle(1, "post_reset");
            check("post_reset_static", 32'(out_port), RV);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
